// File: rtl/ble_event_emitter_if.sv
// UART TX push interface: byte, push strobe and FIFO-full back-pressure.
// master drives tx_data/tx_valid and samples tx_full; slave is the FIFO side.
interface ble_event_emitter_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_full;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_full
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_full
  );
endinterface

// File: rtl/ble_event_emitter.sv
// HM-10 style event emitter: "OK+CONN:<mac>\r\n" / "OK+DISC\r\n" into UART TX.
// Ports: clk, rst_n (sync, active-low), conn_req, disc_req, mac[47:0],
//   tx (master: tx_data, tx_valid, tx_full), busy, done, req_err, connected.
// Optional: BLE_EVT_LOST_EN adds lost_req, emitting "OK+LOST\r\n".
module ble_event_emitter #(
  parameter int GAP_CYCLES = 0,
  parameter bit HEX_UPPER  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                conn_req,
  input  logic                disc_req,
`ifdef BLE_EVT_LOST_EN
  input  logic                lost_req,
`endif
  input  logic [47:0]         mac,
  ble_event_emitter_if.master tx,
  output logic                busy,
  output logic                done,
  output logic                req_err,
  output logic                connected
);

  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_GAP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    K_CONN, K_DISC, K_LOST
  } kind_t;

  localparam int GW = (GAP_CYCLES > 0) ?
    $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [47:0]   mac_q, mac_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          conn_q, conn_d;
  logic          err_q, err_d;

  logic          lost_w;
  logic          last;
  logic [4:0]    hidx;
  logic [3:0]    nib;
  logic [7:0]    hex_b;
  logic [7:0]    byte_b;

`ifdef BLE_EVT_LOST_EN
  assign lost_w = lost_req;
`else
  assign lost_w = 1'b0;
`endif

  assign last = (cnt_q == ((kind_q == K_CONN) ? 5'd21 : 5'd8));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kind_q  <= K_CONN;
      mac_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      conn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      mac_q   <= mac_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      conn_q  <= conn_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    mac_d   = mac_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    conn_d  = conn_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        gap_d = '0;
        // Illegal conn_req always errors; an illegal disc/lost only
        // errors when no conn_req is present to take priority.
        err_d = (conn_req & conn_q) |
                (~conn_q & ~conn_req & (disc_req | lost_w));
        if (conn_req && !conn_q) begin
          kind_d  = K_CONN;
          mac_d   = mac;
          state_d = S_SEND;
        end else if (disc_req && conn_q) begin
          kind_d  = K_DISC;
          state_d = S_SEND;
        end else if (lost_w && conn_q) begin
          kind_d  = K_LOST;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx.tx_full) begin
          cnt_d = cnt_q + 5'd1;
          if (last) begin
            // Link state changes together with the done pulse.
            conn_d  = (kind_q == K_CONN);
            state_d = S_DONE;
          end else if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // MAC nibble for bytes 8..19, most significant nibble first.
  always_comb begin
    hidx  = 5'd19 - cnt_q;
    nib   = 4'(mac_q >> {hidx[3:0], 2'b00});
    hex_b = (nib < 4'd10) ?
      8'h30 + {4'h0, nib} :
      (HEX_UPPER ? 8'h37 : 8'h57) + {4'h0, nib};
  end

  always_comb begin
    byte_b = 8'h00;
    case (kind_q)
      K_CONN: begin
        case (cnt_q)
          5'd0:    byte_b = 8'h4F;
          5'd1:    byte_b = 8'h4B;
          5'd2:    byte_b = 8'h2B;
          5'd3:    byte_b = 8'h43;
          5'd4:    byte_b = 8'h4F;
          5'd5:    byte_b = 8'h4E;
          5'd6:    byte_b = 8'h4E;
          5'd7:    byte_b = 8'h3A;
          5'd20:   byte_b = 8'h0D;
          5'd21:   byte_b = 8'h0A;
          default: byte_b = hex_b;
        endcase
      end
      K_DISC: begin
        case (cnt_q)
          5'd0:    byte_b = 8'h4F;
          5'd1:    byte_b = 8'h4B;
          5'd2:    byte_b = 8'h2B;
          5'd3:    byte_b = 8'h44;
          5'd4:    byte_b = 8'h49;
          5'd5:    byte_b = 8'h53;
          5'd6:    byte_b = 8'h43;
          5'd7:    byte_b = 8'h0D;
          5'd8:    byte_b = 8'h0A;
          default: byte_b = 8'h00;
        endcase
      end
      K_LOST: begin
        case (cnt_q)
          5'd0:    byte_b = 8'h4F;
          5'd1:    byte_b = 8'h4B;
          5'd2:    byte_b = 8'h2B;
          5'd3:    byte_b = 8'h4C;
          5'd4:    byte_b = 8'h4F;
          5'd5:    byte_b = 8'h53;
          5'd6:    byte_b = 8'h54;
          5'd7:    byte_b = 8'h0D;
          5'd8:    byte_b = 8'h0A;
          default: byte_b = 8'h00;
        endcase
      end
      default: byte_b = 8'h00;
    endcase
  end

  assign tx.tx_valid = (state_q == S_SEND) && !tx.tx_full;
  assign tx.tx_data  = (state_q == S_SEND) ? byte_b : 8'h00;

  assign busy      = (state_q == S_SEND) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign req_err   = err_q;
  assign connected = conn_q;

endmodule

// File: tb/tb_ble_event_emitter.sv
// Scoreboard bench for ble_event_emitter: two instances (gap 0 / upper hex,
// gap 3 / lower hex) share stimulus; monitors pop expected bytes and events.
module tb_ble_event_emitter;
  localparam int G1 = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        conn_req = 1'b0;
  logic        disc_req = 1'b0;
  logic        tx_full = 1'b0;
  logic [47:0] mac = '0;
  logic        busy0, done0, err0, con0;
  logic        busy1, done1, err1, con1;

  always #5 clk = ~clk;

  ble_event_emitter_if if0();
  ble_event_emitter_if if1();
  assign if0.tx_full = tx_full;
  assign if1.tx_full = tx_full;

  ble_event_emitter #(.GAP_CYCLES(0), .HEX_UPPER(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .conn_req(conn_req), .disc_req(disc_req),
`ifdef BLE_EVT_LOST_EN
    .lost_req(1'b0),
`endif
    .mac(mac), .tx(if0),
    .busy(busy0), .done(done0), .req_err(err0), .connected(con0)
  );

  ble_event_emitter #(.GAP_CYCLES(G1), .HEX_UPPER(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .conn_req(conn_req), .disc_req(disc_req),
`ifdef BLE_EVT_LOST_EN
    .lost_req(1'b0),
`endif
    .mac(mac), .tx(if1),
    .busy(busy1), .done(done1), .req_err(err1), .connected(con1)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit dq0[$];
  bit dq1[$];
  int ee0 = 0, ee1 = 0;
  int push0 = 0, last0 = 0;
  int idx1 = 0, last1 = 0;
  bit full_seen1 = 1'b0;
  bit model_conn = 1'b0;
  bit rand_full = 1'b0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    end
  endtask

  task automatic fail(string n, logic [63:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, expected nothing", n, act);
  endtask

  function automatic string evt_str(bit is_conn, logic [47:0] m, bit up);
    string h;
    h = $sformatf("%012h", m);
    if (up) h = h.toupper();
    if (is_conn) return {"OK+CONN:", h, "\015\012"};
    return "OK+DISC\015\012";
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (if0.tx_valid) begin
      if (tx_full) fail("valid_while_full0", 1);
      if (q0.size() == 0) fail("extra_byte0", if0.tx_data);
      else chk("byte0", if0.tx_data, q0.pop_front());
      push0++;
      last0 = cyc;
    end
    if (done0) begin
      if (dq0.size() == 0) fail("extra_done0", 1);
      else chk("conn_at_done0", con0, dq0.pop_front());
      chk("done_lat0", cyc - last0, 1);
      chk("busy_at_done0", busy0, 0);
    end
    if (err0) begin
      chk("req_err0", err0, ee0 > 0);
      if (ee0 > 0) ee0--;
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (if1.tx_valid) begin
      if (tx_full) fail("valid_while_full1", 1);
      if (q1.size() == 0) fail("extra_byte1", if1.tx_data);
      else chk("byte1", if1.tx_data, q1.pop_front());
      if (idx1 > 0 && !full_seen1) chk("gap_spacing1", cyc - last1, G1 + 1);
      idx1++;
      last1 = cyc;
      full_seen1 = 1'b0;
    end else begin
      full_seen1 = full_seen1 | tx_full;
    end
    if (done1) begin
      if (dq1.size() == 0) fail("extra_done1", 1);
      else chk("conn_at_done1", con1, dq1.pop_front());
      chk("done_lat1", cyc - last1, 1);
      idx1 = 0;
    end
    if (err1) begin
      chk("req_err1", err1, ee1 > 0);
      if (ee1 > 0) ee1--;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_full) tx_full = ($urandom_range(0, 3) == 0);
  end

  task automatic issue(bit c, bit d, logic [47:0] m);
    bit acc_c, acc_d, e;
    string s0, s1;
    bit ok;
    acc_c = c && !model_conn;
    acc_d = !acc_c && d && model_conn;
    e = (c && model_conn) || (!model_conn && !c && d);
    if (e) begin ee0++; ee1++; end
    if (acc_c || acc_d) begin
      s0 = evt_str(acc_c, m, 1'b1);
      s1 = evt_str(acc_c, m, 1'b0);
      for (int i = 0; i < s0.len(); i++) q0.push_back(s0[i]);
      for (int i = 0; i < s1.len(); i++) q1.push_back(s1[i]);
      model_conn = acc_c;
      dq0.push_back(acc_c);
      dq1.push_back(acc_c);
    end
    conn_req = c;
    disc_req = d;
    mac = m;
    @(posedge clk);
    #1;
    conn_req = 1'b0;
    disc_req = 1'b0;
    mac = 48'({$urandom(), $urandom()});
    @(negedge clk);
    if (acc_c || acc_d) begin
      chk("first_valid0", {busy0, if0.tx_valid}, {1'b1, !tx_full});
      chk("first_valid1", {busy1, if1.tx_valid}, {1'b1, !tx_full});
    end else begin
      chk("rej_quiet", {busy0, if0.tx_valid, busy1, if1.tx_valid}, 0);
    end
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!busy0 && !busy1 && !done0 && !done1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail("idle_timeout", {busy0, busy1});
    if (rst_n) chk("conn_state", {con0, con1}, {model_conn, model_conn});
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit c, d;
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
    c = 0; d = 0;
  end

  initial begin
    bit c, d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {if0.tx_valid, if0.tx_data, busy0, done0, err0, con0,
                       if1.tx_valid, if1.tx_data, busy1, done1, err1, con1}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b1, 1'b0, 48'h010203040506);
    issue(1'b0, 1'b1, 48'h0);

    push0 = 0;
    fork
      issue(1'b1, 1'b0, 48'hA1B2C3D4E5F6);
      begin
        for (int i = 0; i < 300 && push0 < 10; i++) @(negedge clk);
        tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        tx_full = 1'b0;
      end
    join

    issue(1'b1, 1'b0, 48'h112233445566);
    issue(1'b0, 1'b1, 48'h0);
    issue(1'b0, 1'b1, 48'h0);
    issue(1'b1, 1'b1, 48'hFEDCBA987654);
    issue(1'b1, 1'b1, 48'h0);

    push0 = 0;
    fork
      issue(1'b1, 1'b0, 48'h0BADC0FFEE12);
      begin
        for (int i = 0; i < 300 && push0 < 5; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_quiet", {if0.tx_valid, if1.tx_valid,
                          busy0, busy1, con0, con1}, 0);
      end
    join
    q0.delete();
    q1.delete();
    dq0.delete();
    dq1.delete();
    ee0 = 0;
    ee1 = 0;
    model_conn = 1'b0;
    idx1 = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b1, 1'b0, 48'h0BADC0FFEE12);

    rand_full = 1'b1;
    for (int n = 0; n < 40; n++) begin
      c = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 1) == 1);
      issue(c, d, 48'({$urandom(), $urandom()}));
    end
    rand_full = 1'b0;
    tx_full = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("done_drained", dq0.size() + dq1.size(), 0);
    chk("err_drained", ee0 + ee1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
